// File: rtl/prm_edge_chk_seq_if.sv
// Sample-in / verdict-out stream bundle for the edge collision checker.
// Latency: none (wires only).
// Backpressure: in_ready from the checker, out_ready from the consumer.
interface prm_edge_chk_seq_if #(
    parameter int CODE_W  = 15,
    parameter int NUM_OBS = 4,
    parameter int CNT_W   = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [CODE_W-1:0]  in_code;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [NUM_OBS-1:0] out_mask;
    logic               out_blocked;
    logic [CNT_W-1:0]   out_count;

    // Producer of samples / consumer of verdicts.
    modport master (
        output in_valid, in_code, in_last, out_ready,
        input  in_ready, out_valid, out_mask, out_blocked, out_count
    );

    // The checker itself.
    modport slave (
        input  in_valid, in_code, in_last, out_ready,
        output in_ready, out_valid, out_mask, out_blocked, out_count
    );
endinterface

// File: rtl/prm_edge_chk_seq.sv
// Per-edge collision check: ORs per-obstacle table hits over all samples of an edge.
// Latency: verdict valid 2 cycles after the in_last transfer.
// Backpressure: in_ready low from the in_last transfer until out_ready accepts the verdict.
module prm_edge_chk_seq #(
    parameter int CODE_W  = 15,
    parameter int NUM_OBS = 4,
    parameter int CNT_W   = 16,
    localparam int OBS_W  = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               cfg_we,
    input  logic [OBS_W-1:0]   cfg_obs,
    input  logic [CODE_W-1:0]  cfg_addr,
    input  logic               cfg_data,
    output logic               cfg_err,
    input  logic [NUM_OBS-1:0] obs_en,
    prm_edge_chk_seq_if.slave  st
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q;
    logic [NUM_OBS-1:0] mask_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               rd_vld_q;
    logic [NUM_OBS-1:0] rd_bits;
    logic               out_valid_q;
    logic [NUM_OBS-1:0] out_mask_q;
    logic               out_blocked_q;
    logic [CNT_W-1:0]   out_count_q;
    logic               cfg_err_q;

    logic               accepting;
    logic               xfer;
    logic               obs_ok;
    logic               wr_en;
    logic [NUM_OBS-1:0] mask_d;

    // in_ready is gated by RST_n so it is low for the whole reset cycle
    // and high on the very first cycle after release.
    assign accepting = (state_q == S_IDLE) || (state_q == S_RUN);
    assign st.in_ready = RST_n && accepting;
    assign xfer = st.in_valid && st.in_ready;

    // Table writes only land while truly idle, so they never race a lookup.
    assign obs_ok = int'(cfg_obs) < NUM_OBS;
    assign wr_en  = RST_n && cfg_we && (state_q == S_IDLE) && !st.in_valid && obs_ok;

    // Mask including the lookup currently sitting in the read register.
    assign mask_d = mask_q | (rd_vld_q ? rd_bits : '0);

    genvar k;
    generate
        for (k = 0; k < NUM_OBS; k++) begin : g_tbl
            logic tbl_mem [2**CODE_W];
            logic rd_bit_q;

            // One truth table per obstacle; all read in parallel by the sample code.
            always_ff @(posedge CLK) begin
                if (wr_en && (cfg_obs == OBS_W'(k))) begin
                    tbl_mem[cfg_addr] <= cfg_data;
                end
                rd_bit_q <= tbl_mem[st.in_code];
            end

            assign rd_bits[k] = rd_bit_q;
        end
    endgenerate

    // Edge sequencer: accumulate, wait for the last lookup, present, handshake.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q       <= S_IDLE;
            mask_q        <= '0;
            cnt_q         <= '0;
            rd_vld_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            out_mask_q    <= '0;
            out_blocked_q <= 1'b0;
            out_count_q   <= '0;
            cfg_err_q     <= 1'b0;
        end else begin
            cfg_err_q <= cfg_we && !wr_en;
            rd_vld_q  <= xfer;
            mask_q    <= mask_d;
            case (state_q)
                S_IDLE: begin
                    // No lookup is in flight here, so clearing cannot lose a hit.
                    if (xfer) begin
                        mask_q  <= '0;
                        cnt_q   <= CNT_W'(1);
                        state_q <= st.in_last ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        if (st.in_last) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // The last sample's lookup is in rd_bits this cycle.
                    state_q       <= S_OUT;
                    out_valid_q   <= 1'b1;
                    out_mask_q    <= mask_d;
                    out_blocked_q <= |(mask_d & obs_en);
                    out_count_q   <= cnt_q;
                end
                S_OUT: begin
                    if (st.out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign st.out_valid   = out_valid_q;
    assign st.out_mask    = out_mask_q;
    assign st.out_blocked = out_blocked_q;
    assign st.out_count   = out_count_q;
    assign cfg_err        = cfg_err_q;
endmodule
